// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op_e     : operation encoding presented on the 'op' port
//   - estado_e : control FSM states
//   - helpers  : decode of the operation class (division / signed)
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        INACTIVO = 2'b00,
        CALCULO  = 2'b01,
        FIN      = 2'b10
    } estado_e;

    // The upper op bit selects division, the lower bit selects unsigned.
    function automatic logic es_division(input op_e o);
        return o[1];
    endfunction

    function automatic logic es_con_signo(input op_e o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/unidad_muldiv_abs_signo.sv
// -----------------------------------------------------------------------------
// abs_signo
// Conditional two's-complement negation. Used both to turn signed operands
// into magnitudes and to put the sign back on the final product, quotient
// and remainder.
// Ports:
//   valor     : input value (W bits)
//   negar     : 1 = output is -valor, 0 = output is valor
//   resultado : conditioned value (W bits)
// -----------------------------------------------------------------------------
module abs_signo #(
    parameter int W = 32
) (
    input  logic [W-1:0] valor,
    input  logic         negar,
    output logic [W-1:0] resultado
);

    assign resultado = negar ? (~valor + W'(1)) : valor;

endmodule

// File: rtl/unidad_muldiv.sv
// -----------------------------------------------------------------------------
// unidad_muldiv
// Iterative multiply/divide unit. MULT/MULTU use shift-add, DIV/DIVU use
// restoring division; both run one iteration per clock for ANCHO cycles on
// operand magnitudes, and the signs are applied when the result is written.
// Result is available ANCHO+1 cycles after a start is accepted.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   inicio  : start request (accepted only when idle, including the listo cycle)
//   op      : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b    : operands (ANCHO bits)
//   ocupado : operation in progress, starts are ignored
//   listo   : one-cycle pulse, hi/lo/divcero updated
//   hi, lo  : product upper/lower half, or remainder/quotient
//   divcero : last completed operation was a division by zero
// -----------------------------------------------------------------------------
module unidad_muldiv
    import muldiv_pkg::*;
#(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [1:0]       op,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    output logic             ocupado,
    output logic             listo,
    output logic [ANCHO-1:0] hi,
    output logic [ANCHO-1:0] lo,
    output logic             divcero
);

    localparam int               CNT_W  = $clog2(ANCHO + 1);
    localparam logic [CNT_W-1:0] ULTIMA = CNT_W'(ANCHO - 1);

    estado_e            estado_q, estado_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic [ANCHO-1:0]   a_q, a_d;           // raw a, returned in hi on divide-by-zero
    logic [ANCHO-1:0]   opb_q, opb_d;       // |b|: multiplicand or divisor
    logic [ANCHO-1:0]   acc_hi_q, acc_hi_d; // partial product / partial remainder
    logic [ANCHO-1:0]   acc_lo_q, acc_lo_d; // multiplier / dividend shifting into quotient
    logic               signo_a_q, signo_a_d;
    logic               signo_b_q, signo_b_d;
    logic [ANCHO-1:0]   hi_q, hi_d;
    logic [ANCHO-1:0]   lo_q, lo_d;
    logic               divcero_q, divcero_d;
    logic               listo_q, listo_d;
    logic               ocupado_q, ocupado_d;

    // ---------------- operand conditioning ----------------
    op_e              op_in;
    logic             neg_a_in, neg_b_in;
    logic [ANCHO-1:0] mag_a, mag_b;

    assign op_in    = op_e'(op);
    assign neg_a_in = es_con_signo(op_in) & a[ANCHO-1];
    assign neg_b_in = es_con_signo(op_in) & b[ANCHO-1];

    abs_signo #(.W(ANCHO)) u_abs_a (.valor(a), .negar(neg_a_in), .resultado(mag_a));
    abs_signo #(.W(ANCHO)) u_abs_b (.valor(b), .negar(neg_b_in), .resultado(mag_b));

    // ---------------- iteration datapath ----------------
    logic [ANCHO:0]   suma;
    logic [ANCHO:0]   desplazado;
    logic [ANCHO-1:0] resta;
    logic             cabe;

    // Shift-add: add multiplicand when the current multiplier LSB is set;
    // the carry bit is kept so the right shift loses nothing.
    assign suma       = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    // Restoring division: bring in the next dividend bit and trial-subtract.
    // The partial remainder stays below the divisor, so ANCHO+1 bits suffice
    // and a successful subtraction always fits back in ANCHO bits.
    assign desplazado = {acc_hi_q, acc_lo_q[ANCHO-1]};
    assign cabe       = (desplazado >= {1'b0, opb_q});
    assign resta      = desplazado[ANCHO-1:0] - opb_q;

    // ---------------- result sign correction ----------------
    logic               neg_res, neg_resto;
    logic [2*ANCHO-1:0] prod_fix;
    logic [ANCHO-1:0]   coc_fix, resto_fix;

    assign neg_res   = es_con_signo(op_q) & (signo_a_q ^ signo_b_q);
    assign neg_resto = es_con_signo(op_q) & signo_a_q;

    abs_signo #(.W(2*ANCHO)) u_fix_prod (
        .valor({acc_hi_q, acc_lo_q}), .negar(neg_res), .resultado(prod_fix)
    );
    abs_signo #(.W(ANCHO)) u_fix_coc (
        .valor(acc_lo_q), .negar(neg_res), .resultado(coc_fix)
    );
    abs_signo #(.W(ANCHO)) u_fix_resto (
        .valor(acc_hi_q), .negar(neg_resto), .resultado(resto_fix)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= INACTIVO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INACTIVO: if (inicio) estado_d = CALCULO;
            CALCULO:  if (cnt_q == ULTIMA) estado_d = FIN;
            FIN:      estado_d = INACTIVO;
            default:  estado_d = INACTIVO;
        endcase
    end

    // ---------------- FSM: datapath and outputs ----------------
    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        opb_d     = opb_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        signo_a_d = signo_a_q;
        signo_b_d = signo_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divcero_d = divcero_q;
        listo_d   = 1'b0;
        ocupado_d = ocupado_q;

        case (estado_q)
            INACTIVO: begin
                if (inicio) begin
                    op_d      = op_in;
                    a_d       = a;
                    opb_d     = mag_b;
                    acc_hi_d  = '0;
                    acc_lo_d  = mag_a;
                    signo_a_d = neg_a_in;
                    signo_b_d = neg_b_in;
                    cnt_d     = '0;
                    ocupado_d = 1'b1;
                end
            end
            CALCULO: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (es_division(op_q)) begin
                    acc_hi_d = cabe ? resta : desplazado[ANCHO-1:0];
                    acc_lo_d = {acc_lo_q[ANCHO-2:0], cabe};
                end else begin
                    {acc_hi_d, acc_lo_d} = {suma, acc_lo_q[ANCHO-1:1]};
                end
            end
            FIN: begin
                listo_d   = 1'b1;
                ocupado_d = 1'b0;
                if (es_division(op_q)) begin
                    // |b| is zero exactly when b is zero
                    if (opb_q == '0) begin
                        lo_d      = '1;
                        hi_d      = a_q;
                        divcero_d = 1'b1;
                    end else begin
                        lo_d      = coc_fix;
                        hi_d      = resto_fix;
                        divcero_d = 1'b0;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                    divcero_d    = 1'b0;
                end
            end
            default: begin
                ocupado_d = 1'b0;
            end
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            op_q      <= OP_MULT;
            a_q       <= '0;
            opb_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            signo_a_q <= 1'b0;
            signo_b_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divcero_q <= 1'b0;
            listo_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            opb_q     <= opb_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            signo_a_q <= signo_a_d;
            signo_b_q <= signo_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divcero_q <= divcero_d;
            listo_q   <= listo_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign ocupado = ocupado_q;
    assign listo   = listo_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign divcero = divcero_q;

endmodule

// File: tb/tb_unidad_muldiv.sv
// -----------------------------------------------------------------------------
// tb_unidad_muldiv
// Directed and random operations on unidad_muldiv, compared against a
// 64-bit arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_unidad_muldiv;

    localparam int ANCHO = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             inicio;
    logic [1:0]       op;
    logic [ANCHO-1:0] a, b;
    logic             ocupado, listo, divcero;
    logic [ANCHO-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ult_hi = '0;
    logic [31:0] ult_lo = '0;
    logic        ult_dz = 1'b0;

    unidad_muldiv #(.ANCHO(ANCHO)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .op(op), .a(a), .b(b),
        .ocupado(ocupado), .listo(listo), .hi(hi), .lo(lo), .divcero(divcero)
    );

    always #5 clk = ~clk;

    task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_errors++;
            $display("FAIL %s: obtenido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    // Reference: plain 64-bit arithmetic (SV division truncates toward zero,
    // remainder takes the sign of the dividend).
    function automatic void modelo(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dz);
        int              sx = x;
        int              sy = y;
        longint          lx = sx;
        longint          ly = sy;
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint          r;
        longint unsigned ur;
        e_dz = 1'b0;
        case (o)
            2'b00: begin r = lx * ly; e_hi = r[63:32]; e_lo = r[31:0]; end
            2'b01: begin ur = ux * uy; e_hi = ur[63:32]; e_lo = ur[31:0]; end
            default: begin
                if (y == 0) begin
                    e_hi = x; e_lo = 32'hFFFF_FFFF; e_dz = 1'b1;
                end else if (o == 2'b10) begin
                    r = lx / ly; e_lo = r[31:0];
                    r = lx % ly; e_hi = r[31:0];
                end else begin
                    ur = ux / uy; e_lo = ur[31:0];
                    ur = ux % uy; e_hi = ur[31:0];
                end
            end
        endcase
    endfunction

    // Present a start; returns 1 ns after the accepting edge E0 with the
    // operands already scrambled.
    task automatic lanzar(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Wait for listo, scrambling inputs each cycle; optionally pulse inicio
    // with zero operands at cycle pulso_en.
    task automatic esperar_listo(input int pulso_en, output int ciclos);
        ciclos = 0;
        while (ciclos < 40) begin
            @(posedge clk); #1;
            ciclos++;
            if (ciclos == pulso_en) begin
                inicio = 1'b1; a = '0; b = '0;
            end else begin
                inicio = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
            end
            if (listo) break;
        end
        inicio = 1'b0;
        comprobar("listo_llega", listo, 1);
    endtask

    task automatic ejecutar(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input int pulso_en, input string tag);
        logic [31:0] eh, el;
        logic        ed;
        int          c;
        modelo(o, x, y, eh, el, ed);
        lanzar(o, x, y);
        comprobar({tag, "_ocupado"}, ocupado, 1);
        esperar_listo(pulso_en, c);
        comprobar({tag, "_latencia"}, c, 33);
        comprobar({tag, "_hi"}, hi, eh);
        comprobar({tag, "_lo"}, lo, el);
        comprobar({tag, "_divcero"}, divcero, ed);
        comprobar({tag, "_ocupado_listo"}, ocupado, 0);
        ult_hi = eh; ult_lo = el; ult_dz = ed;
    endtask

    // Idle cycles: listo must drop, results must hold.
    task automatic reposo(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom; op = 2'($urandom);
            comprobar("reposo_listo", listo, 0);
            comprobar("reposo_ocupado", ocupado, 0);
            comprobar("reposo_hi", hi, ult_hi);
            comprobar("reposo_lo", lo, ult_lo);
            comprobar("reposo_divcero", divcero, ult_dz);
        end
    endtask

    function automatic logic [31:0] elegir();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          pulsos;
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        rst = 1'b1; inicio = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        comprobar("rst_ocupado", ocupado, 0);
        comprobar("rst_listo", listo, 0);
        comprobar("rst_hi", hi, 0);
        comprobar("rst_lo", lo, 0);
        comprobar("rst_divcero", divcero, 0);
        rst = 1'b0;
        reposo(2);

        // Directed cases
        ejecutar(2'b00, 32'hFFFF_FFFE, 32'd3, 0, "mult_neg");
        reposo(1);
        ejecutar(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        reposo(1);
        ejecutar(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
        reposo(1);
        ejecutar(2'b11, 32'd7, 32'd0, 0, "divu_cero");
        reposo(2);
        ejecutar(2'b00, 32'd5, 32'd5, 0, "mult_limpia_dz");
        reposo(1);
        ejecutar(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_desborde");
        reposo(1);
        ejecutar(2'b10, 32'hFFFF_FFFB, 32'd0, 0, "div_cero_signo");
        reposo(1);
        ejecutar(2'b10, 32'd7, 32'hFFFF_FFFE, 0, "div_b_neg");
        reposo(1);
        ejecutar(2'b11, 32'd100, 32'd7, 10, "divu_ignora");
        reposo(2);

        // Back-to-back
        ejecutar(2'b01, 32'd5, 32'd6, 0, "b2b_1");
        ejecutar(2'b01, 32'd7, 32'd8, 0, "b2b_2");
        reposo(1);

        // Reset mid-operation
        lanzar(2'b10, 32'hFFFF_FF00, 32'd9);
        for (int i = 1; i < 15; i++) begin
            @(posedge clk); #1;
            comprobar("pre_rst_listo", listo, 0);
        end
        rst = 1'b1;
        #1;
        comprobar("rst_mid_hi", hi, 0);
        comprobar("rst_mid_lo", lo, 0);
        comprobar("rst_mid_ocupado", ocupado, 0);
        comprobar("rst_mid_listo", listo, 0);
        comprobar("rst_mid_divcero", divcero, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ult_hi = '0; ult_lo = '0; ult_dz = 1'b0;
        pulsos = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (listo) pulsos++;
        end
        comprobar("rst_sin_listo", pulsos, 0);
        ejecutar(2'b00, 32'd3, 32'd4, 0, "post_rst");
        reposo(1);

        // Random operations, some back-to-back
        for (int k = 0; k < 40; k++) begin
            ro = 2'($urandom);
            rx = elegir();
            ry = elegir();
            ejecutar(ro, rx, ry, 0, "aleatorio");
            if ($urandom_range(0, 1) == 1) reposo(1);
        end
        reposo(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
